vc_fifo_bank: RTL and testbench

Parametrised multi-channel successor to the single main FIFO: one storage bank holding NCH independent circular FIFOs, one per virtual channel. Each channel has its own pointers and occupancy counter and is addressed by a channel index on a shared write port and a shared read port. Per-channel full/empty/almost flags are generated against common programmable thresholds. A sticky error records the first overflow, underflow or bad-channel access. The block sits between the traffic-class classifier (writer) and the VC arbiter (reader).

---
 rtl/vc_fifo_bank_if.sv | 36 +++
 rtl/vc_fifo_bank.sv | 125 ++++++++++++
 tb/tb_vc_fifo_bank.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vc_fifo_bank_if.sv
// Shared write/read port, thresholds and per-channel status of the VC FIFO bank.
// The classifier/arbiter side drives "master"; the bank itself uses "slave".
interface vc_fifo_bank_if #(
    parameter int BW  = 6,
    parameter int AW  = 2,
    parameter int NCH = 4,
    parameter int CW  = 2
);
    logic           wr;
    logic [CW-1:0]  wr_ch;
    logic [BW-1:0]  data_in;
    logic           rd;
    logic [CW-1:0]  rd_ch;
    logic [AW:0]    umbral_bajo;
    logic [AW:0]    umbral_alto;
    logic [BW-1:0]  data_out;
    logic           valid_out;
    logic [NCH-1:0] full;
    logic [NCH-1:0] empty;
    logic [NCH-1:0] almost_full;
    logic [NCH-1:0] almost_empty;
    logic           error_output;
    logic [CW-1:0]  err_ch;

    modport master (
        output wr, wr_ch, data_in, rd, rd_ch, umbral_bajo, umbral_alto,
        input  data_out, valid_out, full, empty, almost_full, almost_empty,
               error_output, err_ch
    );

    modport slave (
        input  wr, wr_ch, data_in, rd, rd_ch, umbral_bajo, umbral_alto,
        output data_out, valid_out, full, empty, almost_full, almost_empty,
               error_output, err_ch
    );
endinterface

// File: rtl/vc_fifo_bank.sv
// NCH independent circular FIFOs sharing one storage bank, addressed {channel, ptr},
// with per-channel flags against shared thresholds and a sticky first-error capture.
module vc_fifo_bank #(
    parameter int BW  = 6,
    parameter int AW  = 2,
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input logic          clk,
    input logic          reset_L,
    vc_fifo_bank_if.slave bus
);
    localparam int             DEPTH   = 1 << AW;
    localparam logic [AW:0]    DEPTH_W = {1'b1, {AW{1'b0}}};
    localparam logic [CW:0]    NCH_W   = (CW+1)'(NCH);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1);
    localparam logic [AW:0]    CNT_ONE = (AW+1)'(1);

    logic [BW-1:0]  mem_r [NCH*DEPTH];
    logic [AW-1:0]  wr_ptr_r [NCH];
    logic [AW-1:0]  rd_ptr_r [NCH];
    logic [AW:0]    count_r [NCH];
    logic [BW-1:0]  data_out_r;
    logic           valid_out_r;
    logic           err_r;
    logic [CW-1:0]  err_ch_r;

    logic           wr_ch_ok_s, rd_ch_ok_s, wr_ok_s, rd_ok_s, wr_err_s, rd_err_s;
    logic [AW:0]    wr_cnt_s, rd_cnt_s;
    logic [AW-1:0]  wr_ptr_s, rd_ptr_s;
    logic [NCH-1:0] inc_s, dec_s;
    logic [NCH-1:0] full_s, empty_s, almost_full_s, almost_empty_s;

    // Accept/reject decision for the shared write and read ports.
    always_comb begin
        wr_ch_ok_s = ({1'b0, bus.wr_ch} < NCH_W);
        rd_ch_ok_s = ({1'b0, bus.rd_ch} < NCH_W);
        if (wr_ch_ok_s) begin
            wr_cnt_s = count_r[bus.wr_ch];
            wr_ptr_s = wr_ptr_r[bus.wr_ch];
        end else begin
            wr_cnt_s = '0;
            wr_ptr_s = '0;
        end
        if (rd_ch_ok_s) begin
            rd_cnt_s = count_r[bus.rd_ch];
            rd_ptr_s = rd_ptr_r[bus.rd_ch];
        end else begin
            rd_cnt_s = '0;
            rd_ptr_s = '0;
        end
        rd_ok_s  = bus.rd && rd_ch_ok_s && (rd_cnt_s != '0);
        // A full channel still takes a write when the same channel frees a slot this cycle.
        wr_ok_s  = bus.wr && wr_ch_ok_s &&
                   ((wr_cnt_s != DEPTH_W) || (rd_ok_s && (bus.rd_ch == bus.wr_ch)));
        wr_err_s = bus.wr && !wr_ok_s;
        rd_err_s = bus.rd && !rd_ok_s;
    end

    // Per-channel increment/decrement strobes and status flags.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            inc_s[i]          = wr_ok_s && (bus.wr_ch == CW'(i));
            dec_s[i]          = rd_ok_s && (bus.rd_ch == CW'(i));
            full_s[i]         = (count_r[i] == DEPTH_W);
            empty_s[i]        = (count_r[i] == '0);
            almost_full_s[i]  = (count_r[i] >= bus.umbral_alto);
            almost_empty_s[i] = (count_r[i] <= bus.umbral_bajo);
        end
    end

    // Pointer and occupancy state for every channel.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < NCH; i++) begin
                wr_ptr_r[i] <= '0;
                rd_ptr_r[i] <= '0;
                count_r[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (inc_s[i]) wr_ptr_r[i] <= wr_ptr_r[i] + PTR_ONE;
                else          wr_ptr_r[i] <= wr_ptr_r[i];
                if (dec_s[i]) rd_ptr_r[i] <= rd_ptr_r[i] + PTR_ONE;
                else          rd_ptr_r[i] <= rd_ptr_r[i];
                case ({inc_s[i], dec_s[i]})
                    2'b10:   count_r[i] <= count_r[i] + CNT_ONE;
                    2'b01:   count_r[i] <= count_r[i] - CNT_ONE;
                    default: count_r[i] <= count_r[i];
                endcase
            end
        end
    end

    // Storage bank; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) mem_r[{bus.wr_ch, wr_ptr_s}] <= bus.data_in;
    end

    // Registered read data and first-error capture (write channel wins on a double failure).
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out_r  <= '0;
            valid_out_r <= 1'b0;
            err_r       <= 1'b0;
            err_ch_r    <= '0;
        end else begin
            valid_out_r <= rd_ok_s;
            if (rd_ok_s) data_out_r <= mem_r[{bus.rd_ch, rd_ptr_s}];
            if (!err_r && (wr_err_s || rd_err_s)) begin
                err_r    <= 1'b1;
                err_ch_r <= wr_err_s ? bus.wr_ch : bus.rd_ch;
            end
        end
    end

    assign bus.data_out     = data_out_r;
    assign bus.valid_out    = valid_out_r;
    assign bus.error_output = err_r;
    assign bus.err_ch       = err_ch_r;
    assign bus.full         = full_s;
    assign bus.empty        = empty_s;
    assign bus.almost_full  = almost_full_s;
    assign bus.almost_empty = almost_empty_s;
endmodule

// File: tb/tb_vc_fifo_bank.sv
// Self-checking bench for vc_fifo_bank: directed scenarios plus random traffic
// against a queue-per-channel reference model.
module tb_vc_fifo_bank;
    localparam int BW = 6, AW = 2, NCH = 4, CW = 2, DEPTH = 4;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk = ~clk;

    vc_fifo_bank_if #(.BW(BW), .AW(AW), .NCH(NCH), .CW(CW)) bus ();
    vc_fifo_bank #(.BW(BW), .AW(AW), .NCH(NCH), .CW(CW)) dut (
        .clk(clk), .reset_L(reset_L), .bus(bus)
    );

    logic [BW-1:0] q [NCH][$];
    logic [BW-1:0] m_dout;
    logic          m_valid, m_err;
    logic [CW-1:0] m_err_ch;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [NCH-1:0] ef, ff, ae, af;
        for (int c = 0; c < NCH; c++) begin
            ef[c] = (q[c].size() == 0);
            ff[c] = (q[c].size() == DEPTH);
            ae[c] = (q[c].size() <= int'(bus.umbral_bajo));
            af[c] = (q[c].size() >= int'(bus.umbral_alto));
        end
        check_val("empty", 32'(bus.empty), 32'(ef));
        check_val("full", 32'(bus.full), 32'(ff));
        check_val("almost_empty", 32'(bus.almost_empty), 32'(ae));
        check_val("almost_full", 32'(bus.almost_full), 32'(af));
        check_val("valid_out", 32'(bus.valid_out), 32'(m_valid));
        check_val("data_out", 32'(bus.data_out), 32'(m_dout));
        check_val("error_output", 32'(bus.error_output), 32'(m_err));
        check_val("err_ch", 32'(bus.err_ch), 32'(m_err_ch));
    endtask

    // One clock cycle of traffic; the model applies the FIFO rules to its queues.
    task automatic step(input bit w, input int wc, input logic [BW-1:0] d, input bit r, input int rc);
        bit ra, wa;
        bus.wr = w; bus.wr_ch = wc[CW-1:0]; bus.data_in = d;
        bus.rd = r; bus.rd_ch = rc[CW-1:0];
        ra = r && (rc < NCH) && (q[rc].size() > 0);
        wa = w && (wc < NCH) && ((q[wc].size() < DEPTH) || (ra && rc == wc));
        if (!m_err && ((w && !wa) || (r && !ra))) begin
            m_err    = 1'b1;
            m_err_ch = (w && !wa) ? wc[CW-1:0] : rc[CW-1:0];
        end
        m_valid = ra;
        if (ra) m_dout = q[rc].pop_front();
        if (wa) q[wc].push_back(d);
        @(posedge clk);
        #1;
        bus.wr = 1'b0; bus.rd = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        bus.wr = 1'b0; bus.rd = 1'b0;
        reset_L = 1'b0;
        #2;
        for (int c = 0; c < NCH; c++) q[c].delete();
        m_dout = '0; m_valid = 1'b0; m_err = 1'b0; m_err_ch = '0;
        check_all();
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        check_all();
    endtask

    initial begin
        logic [BW-1:0] e;
        bus.wr = 1'b0; bus.wr_ch = '0; bus.data_in = '0;
        bus.rd = 1'b0; bus.rd_ch = '0;
        bus.umbral_bajo = 3'd1; bus.umbral_alto = 3'd3;

        do_reset();
        check_val("rst_empty", 32'(bus.empty), 32'h0000_000F);
        check_val("rst_almost_full", 32'(bus.almost_full), 32'h0000_0000);
        check_val("rst_almost_empty", 32'(bus.almost_empty), 32'h0000_000F);

        // Fill ch2, then drain with one read too many.
        for (int k = 1; k <= 4; k++) step(1'b1, 2, BW'(k), 1'b0, 0);
        check_val("fill_full2", 32'(bus.full), 32'h0000_0004);
        for (int k = 1; k <= 5; k++) step(1'b0, 0, '0, 1'b1, 2);
        check_val("drain_err", 32'(bus.error_output), 32'd1);
        check_val("drain_err_ch", 32'(bus.err_ch), 32'd2);

        // Wrap-around on ch0.
        do_reset();
        e = 6'h10;
        for (int k = 0; k < 3; k++) step(1'b1, 0, BW'(6'h10 + k), 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 0, '0, 1'b1, 0);
            check_val("wrap_seq", 32'(bus.data_out), 32'(e));
            e = e + 6'd1;
        end
        for (int k = 3; k < 7; k++) step(1'b1, 0, BW'(6'h10 + k), 1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 0, '0, 1'b1, 0);
            check_val("wrap_seq", 32'(bus.data_out), 32'(e));
            e = e + 6'd1;
        end
        check_val("wrap_no_err", 32'(bus.error_output), 32'd0);

        // Full ch1: simultaneous read/write accepted, lone write rejected.
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 1, BW'(6'h20 + k), 1'b0, 0);
        step(1'b1, 1, 6'h24, 1'b1, 1);
        check_val("full_rw_data", 32'(bus.data_out), 32'h20);
        check_val("full_rw_full", 32'(bus.full), 32'h2);
        check_val("full_rw_err", 32'(bus.error_output), 32'd0);
        step(1'b1, 1, 6'h25, 1'b0, 0);
        check_val("full_w_err", 32'(bus.error_output), 32'd1);
        check_val("full_w_err_ch", 32'(bus.err_ch), 32'd1);
        for (int k = 0; k < 4; k++) step(1'b0, 0, '0, 1'b1, 1);

        // Interleave: write ch3 while reading empty ch0.
        do_reset();
        for (int k = 0; k < 8; k++) step(1'b1, 3, BW'(6'h30 + k), 1'b1, 0);
        check_val("inter_err_ch", 32'(bus.err_ch), 32'd0);
        for (int k = 0; k < 4; k++) step(1'b0, 0, '0, 1'b1, 3);

        // Mid-stream reset with partially filled channels.
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k <= c; k++) step(1'b1, c, BW'($urandom), 1'b0, 0);
        do_reset();
        for (int c = 0; c < NCH; c++) step(1'b0, 0, '0, 1'b1, c);
        check_val("post_rst_err_ch", 32'(bus.err_ch), 32'd0);

        // Random traffic with changing thresholds.
        for (int round = 0; round < 6; round++) begin
            do_reset();
            for (int n = 0; n < 150; n++) begin
                if (n % 20 == 0) begin
                    bus.umbral_bajo = 3'($urandom_range(0, 4));
                    bus.umbral_alto = 3'($urandom_range(0, 4));
                end
                step(1'($urandom_range(0, 1)), int'($urandom_range(0, NCH-1)), BW'($urandom),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, NCH-1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
